// File: rtl/dm_access_ctrl_pkg.sv
// Shared data-memory access constants and helpers.
// Type encodings are common with the load-data extender.
package dm_access_ctrl_pkg;

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_BYTE_S = 3'd1;
  localparam logic [2:0] DM_BYTE_U = 3'd2;
  localparam logic [2:0] DM_HALF_S = 3'd3;
  localparam logic [2:0] DM_HALF_U = 3'd4;

  function automatic logic is_byte(input logic [2:0] t);
    return (t == DM_BYTE_S) || (t == DM_BYTE_U);
  endfunction

  function automatic logic is_half(input logic [2:0] t);
    return (t == DM_HALF_S) || (t == DM_HALF_U);
  endfunction

  // Unknown encodings are treated as word accesses.
  function automatic logic is_aligned(input logic [2:0] t,
                                      input logic [1:0] a);
    logic ok;
    ok = 1'b1;
    if (is_half(t)) begin
      ok = (a[0] == 1'b0);
    end else if (!is_byte(t)) begin
      ok = (a == 2'b00);
    end
    return ok;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_be_gen.sv
// Byte-enable generation and store-lane steering.
module dm_be_gen
  import dm_access_ctrl_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  addr_low_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    unique case (1'b1)
      is_byte(type_i): begin
        be_o    = 4'b0001 << addr_low_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      is_half(type_i): begin
        be_o    = addr_low_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: one bus
// transaction per load/store, with timeout and stall.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [2:0]  rd_type,
  output logic [1:0]  rd_addr_low,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [7:0] TERM = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  type_q;
  logic [1:0]  alow_q;
  logic        write_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;
  logic [2:0]  rd_type_q;
  logic [1:0]  rd_alow_q;
  logic        bus_err_q;

  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic        idle;
  logic        aligned;
  logic        accept;
  logic        misal;
  logic        term;

  dm_be_gen u_be_gen (
    .type_i     (req_type),
    .addr_low_i (req_addr[1:0]),
    .wdata_i    (req_wdata),
    .be_o       (be_w),
    .wdata_o    (wdata_w)
  );

  assign idle    = (state_q == S_IDLE);
  assign aligned = is_aligned(req_type, req_addr[1:0]);
  assign accept  = idle & req_valid & aligned;
  assign misal   = idle & req_valid & ~aligned;
  assign term    = (cnt_q == TERM);

  assign stall    = ~reset & (accept | (state_q == S_BUSY));
  assign exc_adel = ~reset & misal & ~req_write;
  assign exc_ades = ~reset & misal & req_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      type_q      <= '0;
      alow_q      <= '0;
      write_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_type_q   <= '0;
      rd_alow_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_BUSY;
            cnt_q       <= '0;
            type_q      <= req_type;
            alow_q      <= req_addr[1:0];
            write_q     <= req_write;
            bus_req_q   <= 1'b1;
            bus_we_q    <= req_write;
            bus_addr_q  <= {req_addr[31:2], 2'b00};
            bus_be_q    <= req_write ? be_w : 4'b1111;
            bus_wdata_q <= req_write ? wdata_w : 32'h0;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          // An ack on the terminal count still completes cleanly.
          if (bus_ack || term) begin
            state_q    <= S_DONE;
            bus_req_q  <= 1'b0;
            rd_valid_q <= ~write_q;
            bus_err_q  <= ~bus_ack;
            rd_type_q  <= type_q;
            rd_alow_q  <= alow_q;
            if (!write_q) begin
              rd_data_q <= bus_ack ? bus_rdata : 32'h0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_be      = bus_be_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_type     = rd_type_q;
  assign rd_addr_low = rd_alow_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl.
// Expected transactions are queued at drive time.
module tb_dm_access_ctrl;
  import dm_access_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [2:0]  rd_type;
  logic [1:0]  rd_addr_low;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;

  dm_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_type    (req_type),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_type     (rd_type),
    .rd_addr_low (rd_addr_low),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        rv;
    logic        err;
    logic [2:0]  typ;
    logic [1:0]  alow;
    int          busy;
  } exp_t;

  exp_t        sbq[$];
  int          checks;
  int          failures;
  logic [31:0] last_rd;

  function automatic exp_t model(input logic [2:0] t,
                                 input logic wr,
                                 input logic [31:0] a,
                                 input logic [31:0] wd,
                                 input int ack_at,
                                 input logic [31:0] rdat);
    exp_t e;
    bit   acked;
    acked  = (ack_at >= 1) && (ack_at <= TO);
    e.addr = a & 32'hFFFF_FFFC;
    e.we   = wr;
    e.typ  = t;
    e.alow = a[1:0];
    e.be   = 4'hF;
    e.wdata = 32'h0;
    if (wr) begin
      case (t)
        DM_BYTE_S, DM_BYTE_U: begin
          case (a[1:0])
            2'd0: e.be = 4'b0001;
            2'd1: e.be = 4'b0010;
            2'd2: e.be = 4'b0100;
            default: e.be = 4'b1000;
          endcase
          e.wdata = wd[7:0] * 32'h0101_0101;
        end
        DM_HALF_S, DM_HALF_U: begin
          e.be    = a[1] ? 4'b1100 : 4'b0011;
          e.wdata = {wd[15:0], wd[15:0]};
        end
        default: begin
          e.be    = 4'hF;
          e.wdata = wd;
        end
      endcase
    end
    e.busy  = acked ? ack_at : TO;
    e.err   = !acked;
    e.rv    = !wr;
    e.rdata = acked ? rdat : 32'h0;
    return e;
  endfunction

  task automatic do_access(input logic [2:0] t,
                           input logic wr,
                           input logic [31:0] a,
                           input logic [31:0] wd,
                           input int ack_at,
                           input logic [31:0] rdat);
    exp_t cur;
    int   n;
    int   stalls;
    bit   done;
    sbq.push_back(model(t, wr, a, wd, ack_at, rdat));
    req_valid = 1'b1;
    req_write = wr;
    req_type  = t;
    req_addr  = a;
    req_wdata = wd;
    #1;
    checks++;
    if (stall !== 1'b1 || exc_adel !== 1'b0 || exc_ades !== 1'b0)
      begin
      failures++;
      $display("FAIL accept: stall=%b adel=%b ades=%b want 1 0 0",
               stall, exc_adel, exc_ades);
    end
    @(negedge clk);
    cur = sbq.pop_front();
    n = 0;
    stalls = 0;
    done = 0;
    while (!done && n < 20) begin
      if (bus_req === 1'b1) begin
        n++;
        if (stall === 1'b1) stalls++;
        checks++;
        if (bus_addr !== cur.addr || bus_be !== cur.be ||
            bus_wdata !== cur.wdata || bus_we !== cur.we) begin
          failures++;
          $display("FAIL bus_cyc%0d: a=%h be=%b wd=%h we=%b want %h %b %h %b",
                   n, bus_addr, bus_be, bus_wdata, bus_we,
                   cur.addr, cur.be, cur.wdata, cur.we);
        end
        bus_ack   = (n == ack_at);
        bus_rdata = (n == ack_at) ? rdat : 32'h0BAD_F00D;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    bus_ack = 1'b0;
    checks++;
    if (n !== cur.busy || stalls !== cur.busy) begin
      failures++;
      $display("FAIL busy_len: busy=%0d stalls=%0d want %0d",
               n, stalls, cur.busy);
    end
    if (cur.rv) last_rd = cur.rdata;
    checks++;
    if (stall !== 1'b0 || rd_valid !== cur.rv ||
        bus_err !== cur.err || rd_data !== last_rd ||
        rd_type !== cur.typ || rd_addr_low !== cur.alow) begin
      failures++;
      $display("FAIL done: st=%b rv=%b err=%b d=%h t=%0d al=%0d want 0 %b %b %h %0d %0d",
               stall, rd_valid, bus_err, rd_data, rd_type, rd_addr_low,
               cur.rv, cur.err, last_rd, cur.typ, cur.alow);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || bus_err !== 1'b0 || bus_req !== 1'b0 ||
        stall !== 1'b0 || rd_data !== last_rd) begin
      failures++;
      $display("FAIL after_done: rv=%b err=%b req=%b st=%b d=%h want 0 0 0 0 %h",
               rd_valid, bus_err, bus_req, stall, rd_data, last_rd);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || rd_valid !== 1'b0 ||
        bus_err !== 1'b0 || rd_data !== 32'h0 || bus_be !== 4'h0 ||
        bus_addr !== 32'h0 || bus_we !== 1'b0 || exc_adel !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: req=%b st=%b rv=%b err=%b d=%h be=%b",
               bus_req, stall, rd_valid, bus_err, rd_data, bus_be);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_first_after_reset();
    @(negedge clk);
    reset = 1'b0;
    do_access(DM_WORD, 1'b0, 32'h0000_1000, 32'h0, 1, 32'hDEAD_BEEF);
  endtask

  task automatic test_byte_store();
    do_access(DM_BYTE_U, 1'b1, 32'h0000_1003, 32'h0000_00A5, 4, 32'h0);
  endtask

  task automatic test_misaligned();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_type  = DM_HALF_S;
    req_addr  = 32'h0000_2001;
    #1;
    checks++;
    if (exc_adel !== 1'b1 || exc_ades !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL misal_load: adel=%b ades=%b st=%b want 1 0 0",
               exc_adel, exc_ades, stall);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL misal_nobus: req=%b st=%b want 0 0",
                 bus_req, stall);
      end
    end
    req_write = 1'b1;
    req_type  = DM_WORD;
    req_addr  = 32'h0000_1002;
    #1;
    checks++;
    if (exc_ades !== 1'b1 || exc_adel !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL misal_store: adel=%b ades=%b st=%b want 0 1 0",
               exc_adel, exc_ades, stall);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin
      failures++;
      $display("FAIL misal_store_nobus: req=%b want 0", bus_req);
    end
  endtask

  task automatic test_half_store();
    do_access(DM_HALF_U, 1'b1, 32'h0000_2002, 32'h0000_1234, 2, 32'h0);
  endtask

  task automatic test_timeout();
    do_access(DM_WORD, 1'b0, 32'h0000_4000, 32'h0, 0, 32'h0);
    do_access(DM_HALF_U, 1'b0, 32'h0000_4002, 32'h0, TO, 32'h8765_4321);
    do_access(DM_BYTE_S, 1'b1, 32'h0000_4001, 32'h0000_0077, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  t;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      t = 3'($urandom_range(0, 4));
      a = $urandom;
      if (is_half(t)) a[0] = 1'b0;
      else if (!is_byte(t)) a[1:0] = 2'b00;
      do_access(t, 1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 5), $urandom);
    end
  endtask

  task automatic test_reset_busy();
    exp_t cur;
    sbq.push_back(model(DM_WORD, 1'b0, 32'h0000_3000, 32'h0, 0, 32'h0));
    req_valid = 1'b1;
    req_write = 1'b0;
    req_type  = DM_WORD;
    req_addr  = 32'h0000_3000;
    @(negedge clk);
    cur = sbq.pop_front();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== cur.addr || bus_be !== cur.be) begin
      failures++;
      $display("FAIL rb_busy1: req=%b a=%h be=%b want 1 %h %b",
               bus_req, bus_addr, bus_be, cur.addr, cur.be);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rb_immediate: req=%b st=%b want 0 0", bus_req, stall);
    end
    last_rd = 32'h0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || bus_err !== 1'b0 || rd_data !== 32'h0) begin
        failures++;
        $display("FAIL rb_nodone: rv=%b err=%b d=%h want 0 0 0",
                 rd_valid, bus_err, rd_data);
      end
    end
    req_valid = 1'b0;
    reset = 1'b0;
    do_access(DM_BYTE_U, 1'b0, 32'h0000_3002, 32'h0, 2, 32'h00C0_FFEE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    last_rd   = 32'h0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_type  = DM_WORD;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    test_reset();
    test_first_after_reset();
    test_byte_store();
    test_misaligned();
    test_half_store();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d entries want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
